// File: rtl/crypt_stream_framer.sv
// Framed byte-stream front end for the 8-bit cipher core: decodes key/data
// frames, keeps the active key and presents each ciphertext on valid/ready.

module encrypt (
    input  logic [7:0] key,
    input  logic [7:0] pt,
    output logic [7:0] ct
);
    logic [7:0] mix;

    // Whiten, rotate left by three, then add the nibble-swapped key.
    assign mix = pt ^ key;
    assign ct  = {mix[4:0], mix[7:5]} + {key[3:0], key[7:4]};
endmodule

module crypt_stream_framer #(
    parameter logic [7:0] HDR_KEY   = 8'hA5,
    parameter logic [7:0] HDR_DATA  = 8'h5A,
    parameter logic [7:0] KEY_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        key_loaded,
    output logic        hdr_err,
    output logic [15:0] enc_count
);
    typedef enum logic [2:0] {
        IDLE,
        GET_KEY,
        GET_DATA,
        CALC,
        SEND
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  key_q, key_d;
    logic [7:0]  pt_q, pt_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_valid_q, out_valid_d;
    logic        key_loaded_q, key_loaded_d;
    logic        hdr_err_q, hdr_err_d;
    logic [15:0] enc_count_q, enc_count_d;
    logic [7:0]  ct;
    logic        in_xfer;
    logic        out_xfer;

    encrypt u_encrypt (
        .key (key_q),
        .pt  (pt_q),
        .ct  (ct)
    );

    // Ready is a pure state decode so no combinational path reaches in_valid.
    assign in_ready = (state_q == IDLE) || (state_q == GET_KEY) || (state_q == GET_DATA);
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d      = state_q;
        key_d        = key_q;
        pt_d         = pt_q;
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        key_loaded_d = key_loaded_q;
        hdr_err_d    = 1'b0;
        enc_count_d  = enc_count_q;

        unique case (state_q)
            IDLE: begin
                if (in_xfer) begin
                    if (in_data == HDR_KEY) begin
                        state_d = GET_KEY;
                    end else if (in_data == HDR_DATA) begin
                        state_d = GET_DATA;
                    end else begin
                        hdr_err_d = 1'b1;
                    end
                end
            end
            GET_KEY: begin
                if (in_xfer) begin
                    key_d        = in_data;
                    key_loaded_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            GET_DATA: begin
                if (in_xfer) begin
                    pt_d    = in_data;
                    state_d = CALC;
                end
            end
            CALC: begin
                out_data_d  = ct;
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_xfer) begin
                    out_valid_d = 1'b0;
                    enc_count_d = enc_count_q + 16'd1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            key_q        <= KEY_RESET;
            pt_q         <= 8'h00;
            out_data_q   <= 8'h00;
            out_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            hdr_err_q    <= 1'b0;
            enc_count_q  <= 16'h0000;
        end else begin
            state_q      <= state_d;
            key_q        <= key_d;
            pt_q         <= pt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            key_loaded_q <= key_loaded_d;
            hdr_err_q    <= hdr_err_d;
            enc_count_q  <= enc_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign key_loaded = key_loaded_q;
    assign hdr_err    = hdr_err_q;
    assign enc_count  = enc_count_q;
endmodule

// File: tb/tb_crypt_stream_framer.sv
// Directed bench for crypt_stream_framer; ciphertexts are hand-computed from
// ct = rotl3(pt ^ key) + swap_nibbles(key).

module tb_crypt_stream_framer;
    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        key_loaded;
    logic        hdr_err;
    logic [15:0] enc_count;

    int n_tests;
    int n_fail;

    crypt_stream_framer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .key_loaded (key_loaded),
        .hdr_err    (hdr_err),
        .enc_count  (enc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one byte and hold it until the framer accepts it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        int waited;
        in_data  = b;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 16'(in_ready), 16'd1);
        tick();
        in_valid = 1'b0;
        in_data  = 8'h00;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_data   = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;

        // Reset then idle.
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        check("rst_in_ready",   16'(in_ready),   16'd1);
        check("rst_out_valid",  16'(out_valid),  16'd0);
        check("rst_out_data",   16'(out_data),   16'h00);
        check("rst_key_loaded", 16'(key_loaded), 16'd0);
        check("rst_hdr_err",    16'(hdr_err),    16'd0);
        check("rst_enc_count",  enc_count,       16'd0);

        // Backpressure with the reset key: encrypt(00,FF) = FF.
        out_ready = 1'b0;
        send_byte(8'h5A);
        send_byte(8'hFF);
        check("bp_calc_valid", 16'(out_valid), 16'd0);
        check("bp_calc_ready", 16'(in_ready),  16'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 16'(out_valid), 16'd1);
            check("bp_hold_data",  16'(out_data),  16'hFF);
            check("bp_hold_ready", 16'(in_ready),  16'd0);
            check("bp_hold_count", enc_count,      16'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("bp_done_valid", 16'(out_valid), 16'd0);
        check("bp_done_count", enc_count,      16'd1);
        check("bp_done_ready", 16'(in_ready),  16'd1);
        tick();
        check("bp_single_count", enc_count, 16'd1);

        // Bad header, then A5 taken literally as plaintext: encrypt(00,A5) = 2D.
        out_ready = 1'b0;
        send_byte(8'h12);
        check("bad_hdr_pulse", 16'(hdr_err), 16'd1);
        send_byte(8'h5A);
        check("bad_hdr_clear", 16'(hdr_err), 16'd0);
        send_byte(8'hA5);
        check("lit_calc_ready", 16'(in_ready),   16'd0);
        check("lit_no_key",     16'(key_loaded), 16'd0);
        tick();
        check("lit_valid", 16'(out_valid), 16'h1);
        check("lit_data",  16'(out_data),  16'h2D);
        out_ready = 1'b1;
        tick();
        check("lit_count", enc_count, 16'd2);

        // Back-to-back bad headers give back-to-back pulses.
        send_byte(8'h00);
        check("b2b_pulse0", 16'(hdr_err), 16'd1);
        send_byte(8'hFF);
        check("b2b_pulse1", 16'(hdr_err), 16'd1);
        tick();
        check("b2b_clear", 16'(hdr_err), 16'd0);

        // Key 3C then data 41: encrypt(3C,41) = AE.
        send_byte(8'hA5);
        check("key_not_yet", 16'(key_loaded), 16'd0);
        send_byte(8'h3C);
        check("key_loaded", 16'(key_loaded), 16'd1);
        check("key_no_out", 16'(out_valid),  16'd0);
        send_byte(8'h5A);
        send_byte(8'h41);
        check("kd_calc_valid", 16'(out_valid), 16'd0);
        tick();
        check("kd_valid", 16'(out_valid), 16'd1);
        check("kd_data",  16'(out_data),  16'hAE);
        tick();
        check("kd_done_valid", 16'(out_valid), 16'd0);
        check("kd_count",      enc_count,      16'd3);
        check("kd_ready",      16'(in_ready),  16'd1);

        // Counter wrap: preload FFFF, one frame with key 3C, pt 00 -> A4.
        dut.enc_count_q = 16'hFFFF;
        send_byte(8'h5A);
        send_byte(8'h00);
        tick();
        check("wrap_data",  16'(out_data), 16'hA4);
        check("wrap_count_pre", enc_count, 16'hFFFF);
        tick();
        check("wrap_count", enc_count, 16'h0000);

        // Reset mid-SEND, asynchronously between edges.
        out_ready = 1'b0;
        send_byte(8'h5A);
        send_byte(8'h41);
        tick();
        check("mid_send_valid", 16'(out_valid), 16'd1);
        check("mid_send_data",  16'(out_data),  16'hAE);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid",  16'(out_valid),  16'd0);
        check("arst_out_data",   16'(out_data),   16'h00);
        check("arst_key_loaded", 16'(key_loaded), 16'd0);
        check("arst_enc_count",  enc_count,       16'd0);
        check("arst_in_ready",   16'(in_ready),   16'd1);
        tick();
        #2 rst_n = 1'b1;
        tick();

        // Key is back to 00: encrypt(00,41) = 0A.
        out_ready = 1'b1;
        send_byte(8'h5A);
        send_byte(8'h41);
        tick();
        check("post_rst_data", 16'(out_data), 16'h0A);
        tick();
        check("post_rst_count", enc_count, 16'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
